// File: rtl/polara_chip_bringup_seq.sv
// polara_chip_bringup_seq: power-up sequencer for the Polara chip and its FLL.
// Sequence: FLL reset, range config, lock wait, chip clock enable, chip reset release.
// Lock is watched in RUN; a lock timeout or a loss of lock parks the chip in ERROR.
module polara_chip_bringup_seq #(
  parameter int RST_HOLD_CYCLES   = 1024,
  parameter int CLK_SETTLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT      = 65536,
  parameter int LOCK_STABLE       = 16,
  parameter int CFG_PULSE         = 4,
  parameter int CNT_W             = 17
) (
  input  logic       chipset_clk,
  input  logic       chipset_rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       use_fll,
  input  logic       async_mux_cfg,
  input  logic [3:0] fll_range_cfg,
  input  logic       fll_lock,
  output logic       chip_rst_n,
  output logic       chip_clk_en,
  output logic       chip_clk_mux_sel,
  output logic       chip_async_mux,
  output logic       fll_rst_n,
  output logic       fll_bypass,
  output logic       fll_opmode,
  output logic       fll_cfg_req,
  output logic [3:0] fll_range,
  output logic       chip_ready,
  output logic       seq_error,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLL_RST  = 3'd1,
    FLL_CFG  = 3'd2,
    FLL_WAIT = 3'd3,
    CLK_EN   = 3'd4,
    CHIP_RST = 3'd5,
    RUN      = 3'd6,
    ERROR    = 3'd7
  } state_t;

  typedef struct packed {
    logic       chip_rst_n;
    logic       chip_clk_en;
    logic       chip_clk_mux_sel;
    logic       chip_async_mux;
    logic       fll_rst_n;
    logic       fll_bypass;
    logic       fll_opmode;
    logic       fll_cfg_req;
    logic [3:0] fll_range;
    logic       chip_ready;
    logic       seq_error;
  } pins_t;

  localparam pins_t PINS_RST = '{
    chip_rst_n: 1'b0, chip_clk_en: 1'b0, chip_clk_mux_sel: 1'b0, chip_async_mux: 1'b0,
    fll_rst_n: 1'b0, fll_bypass: 1'b1, fll_opmode: 1'b0, fll_cfg_req: 1'b0,
    fll_range: 4'h0, chip_ready: 1'b0, seq_error: 1'b0};

  // Terminal counts: the counter is 0 on the first edge in a state, so a
  // state of duration N leaves when the counter shows N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLK_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CFG_LAST    = CNT_W'(CFG_PULSE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_CNT  = CNT_W'(LOCK_STABLE);

  state_t           state, state_nxt;
  pins_t            pins, pins_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stab;
  logic             start_q;
  logic             lock_meta, lock_s;
  logic             cfg_use_fll, cfg_async;
  logic [3:0]       cfg_range;
  logic             cfg_use_fll_nxt, cfg_async_nxt;
  logic [3:0]       cfg_range_nxt;
  logic             launch;

  // A held-high start must not relaunch, so only a sampled rising edge counts.
  assign launch = (state == IDLE) && start && !start_q;

  // Config latches on launch; the output decode needs the value for the new state.
  always_comb begin
    cfg_use_fll_nxt = launch ? use_fll       : cfg_use_fll;
    cfg_async_nxt   = launch ? async_mux_cfg : cfg_async;
    cfg_range_nxt   = launch ? fll_range_cfg : cfg_range;
  end

  // State register, shared state counter, lock synchronizer, stability counter and output flops.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      state       <= IDLE;
      pins        <= PINS_RST;
      cnt         <= '0;
      stab        <= '0;
      start_q     <= 1'b0;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      cfg_use_fll <= 1'b0;
      cfg_async   <= 1'b0;
      cfg_range   <= 4'h0;
    end else begin
      state       <= state_nxt;
      pins        <= pins_nxt;
      cnt         <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      start_q     <= start;
      lock_meta   <= fll_lock;
      lock_s      <= lock_meta;
      cfg_use_fll <= cfg_use_fll_nxt;
      cfg_async   <= cfg_async_nxt;
      cfg_range   <= cfg_range_nxt;
      if (state != FLL_WAIT || !lock_s) stab <= '0;
      else if (stab != STABLE_CNT)      stab <= stab + CNT_W'(1);
    end
  end

  // Next-state: timed walk through the sequence; stop overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (launch) state_nxt = use_fll ? FLL_RST : CLK_EN;
      FLL_RST:  if (cnt == RST_LAST) state_nxt = FLL_CFG;
      FLL_CFG:  if (cnt == CFG_LAST) state_nxt = FLL_WAIT;
      FLL_WAIT: begin
        // Lock is checked first so it wins a same-cycle tie with the timeout.
        if (stab == STABLE_CNT)    state_nxt = CLK_EN;
        else if (cnt == TMO_LAST)  state_nxt = ERROR;
      end
      CLK_EN:   if (cnt == SETTLE_LAST) state_nxt = CHIP_RST;
      CHIP_RST: if (cnt == RST_LAST) state_nxt = RUN;
      RUN:      if (cfg_use_fll && !lock_s) state_nxt = ERROR;
      ERROR:    state_nxt = ERROR;
      default:  state_nxt = IDLE;
    endcase
    if (stop) state_nxt = IDLE;
  end

  // Output decode of the next state; pins not named for a state keep their last value.
  always_comb begin
    pins_nxt = pins;
    case (state_nxt)
      IDLE:     pins_nxt = PINS_RST;
      FLL_RST:  pins_nxt.fll_rst_n = 1'b0;
      FLL_CFG: begin
        pins_nxt.fll_rst_n   = 1'b1;
        pins_nxt.fll_range   = cfg_range_nxt;
        pins_nxt.fll_cfg_req = 1'b1;
      end
      FLL_WAIT: begin
        pins_nxt.fll_bypass  = 1'b0;
        pins_nxt.fll_opmode  = 1'b1;
        pins_nxt.fll_cfg_req = 1'b0;
      end
      CLK_EN: begin
        pins_nxt.chip_clk_en      = 1'b1;
        pins_nxt.chip_clk_mux_sel = cfg_use_fll_nxt;
      end
      CHIP_RST: pins_nxt.chip_rst_n = 1'b0;
      RUN:      pins_nxt.chip_rst_n = 1'b1;
      ERROR: begin
        pins_nxt.chip_rst_n  = 1'b0;
        pins_nxt.chip_clk_en = 1'b0;
        pins_nxt.fll_rst_n   = 1'b0;
        pins_nxt.fll_bypass  = 1'b1;
        pins_nxt.fll_opmode  = 1'b0;
      end
      default:  pins_nxt = PINS_RST;
    endcase
    pins_nxt.chip_ready     = (state_nxt == RUN);
    pins_nxt.seq_error      = (state_nxt == ERROR);
    pins_nxt.chip_async_mux = (state_nxt != IDLE) && cfg_async_nxt;
  end

  assign chip_rst_n       = pins.chip_rst_n;
  assign chip_clk_en      = pins.chip_clk_en;
  assign chip_clk_mux_sel = pins.chip_clk_mux_sel;
  assign chip_async_mux   = pins.chip_async_mux;
  assign fll_rst_n        = pins.fll_rst_n;
  assign fll_bypass       = pins.fll_bypass;
  assign fll_opmode       = pins.fll_opmode;
  assign fll_cfg_req      = pins.fll_cfg_req;
  assign fll_range        = pins.fll_range;
  assign chip_ready       = pins.chip_ready;
  assign seq_error        = pins.seq_error;
  assign seq_state        = state;

endmodule

// File: tb/tb_polara_chip_bringup_seq.sv
// Directed bench for polara_chip_bringup_seq with R=8, C=4, P=4, timeout 64, stable 4.
// Inputs change 1ns after a rising edge; outputs are sampled there too, i.e. after
// the edge has settled, so "after edge k" below means the value registered at edge k.
module tb_polara_chip_bringup_seq;

  logic       chipset_clk = 1'b0;
  logic       chipset_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       use_fll = 1'b0;
  logic       async_mux_cfg = 1'b0;
  logic [3:0] fll_range_cfg = 4'h0;
  logic       fll_lock = 1'b0;
  logic       chip_rst_n, chip_clk_en, chip_clk_mux_sel, chip_async_mux;
  logic       fll_rst_n, fll_bypass, fll_opmode, fll_cfg_req;
  logic [3:0] fll_range;
  logic       chip_ready, seq_error;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;

  // Output vector: rst_n,clk_en,mux_sel,async_mux, fll_rst_n,bypass,opmode,cfg_req, range[4], ready,error, state[3]
  logic [16:0] outs;
  assign outs = {chip_rst_n, chip_clk_en, chip_clk_mux_sel, chip_async_mux,
                 fll_rst_n, fll_bypass, fll_opmode, fll_cfg_req,
                 fll_range, chip_ready, seq_error, seq_state};
  localparam logic [16:0] IDLE_V = 17'h00800;

  polara_chip_bringup_seq #(
    .RST_HOLD_CYCLES(8), .CLK_SETTLE_CYCLES(4), .LOCK_TIMEOUT(64),
    .LOCK_STABLE(4), .CFG_PULSE(4), .CNT_W(17)
  ) dut (
    .chipset_clk(chipset_clk), .chipset_rst_n(chipset_rst_n),
    .start(start), .stop(stop), .use_fll(use_fll), .async_mux_cfg(async_mux_cfg),
    .fll_range_cfg(fll_range_cfg), .fll_lock(fll_lock),
    .chip_rst_n(chip_rst_n), .chip_clk_en(chip_clk_en),
    .chip_clk_mux_sel(chip_clk_mux_sel), .chip_async_mux(chip_async_mux),
    .fll_rst_n(fll_rst_n), .fll_bypass(fll_bypass), .fll_opmode(fll_opmode),
    .fll_cfg_req(fll_cfg_req), .fll_range(fll_range),
    .chip_ready(chip_ready), .seq_error(seq_error), .seq_state(seq_state)
  );

  always #5 chipset_clk = ~chipset_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge chipset_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    step(2);
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL reset_hold got=%h want=%h", outs, IDLE_V); end
    chipset_rst_n = 1'b1;
    step(3);
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL reset_idle got=%h want=%h", outs, IDLE_V); end
  endtask

  task automatic test_bypass_boot;
    use_fll = 1'b0; async_mux_cfg = 1'b0; fll_range_cfg = 4'h5;
    start = 1'b1; step(1); start = 1'b0;   // after edge k
    checks++; if (outs !== {4'b0100, 4'b0100, 4'h0, 2'b00, 3'd4}) begin errors++; $display("FAIL byp_clk_en got=%h want=%h", outs, {4'b0100, 4'b0100, 4'h0, 2'b00, 3'd4}); end
    step(3);                              // k+3
    checks++; if (seq_state !== 3'd4) begin errors++; $display("FAIL byp_settle state=%0d want=4", seq_state); end
    step(1);                              // k+4
    checks++; if ({seq_state, chip_clk_en, chip_rst_n} !== {3'd5, 2'b10}) begin errors++; $display("FAIL byp_chip_rst got=%b want=%b", {seq_state, chip_clk_en, chip_rst_n}, {3'd5, 2'b10}); end
    step(7);                              // k+11
    checks++; if ({seq_state, chip_ready} !== {3'd5, 1'b0}) begin errors++; $display("FAIL byp_pre_run got=%b want=%b", {seq_state, chip_ready}, {3'd5, 1'b0}); end
    step(1);                              // k+12
    checks++; if (outs !== {4'b1100, 4'b0100, 4'h0, 2'b10, 3'd6}) begin errors++; $display("FAIL byp_run got=%h want=%h", outs, {4'b1100, 4'b0100, 4'h0, 2'b10, 3'd6}); end
    step(20);                             // lock is low but ignored on the bypass path
    checks++; if (seq_state !== 3'd6) begin errors++; $display("FAIL byp_run_hold state=%0d want=6", seq_state); end
    stop = 1'b1; step(1); stop = 1'b0;
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL byp_stop got=%h want=%h", outs, IDLE_V); end
  endtask

  task automatic test_fll_boot;
    use_fll = 1'b1; async_mux_cfg = 1'b1; fll_range_cfg = 4'hA; fll_lock = 1'b0;
    start = 1'b1; step(1); start = 1'b0;  // after edge k
    use_fll = 1'b0; async_mux_cfg = 1'b0; fll_range_cfg = 4'h3;  // must not disturb the latched config
    checks++; if (outs !== {4'b0001, 4'b0100, 4'h0, 2'b00, 3'd1}) begin errors++; $display("FAIL fll_rst got=%h want=%h", outs, {4'b0001, 4'b0100, 4'h0, 2'b00, 3'd1}); end
    step(7);                              // k+7
    checks++; if ({seq_state, fll_cfg_req} !== {3'd1, 1'b0}) begin errors++; $display("FAIL fll_rst_end got=%b want=%b", {seq_state, fll_cfg_req}, {3'd1, 1'b0}); end
    step(1);                              // k+8
    checks++; if (outs !== {4'b0001, 4'b1101, 4'hA, 2'b00, 3'd2}) begin errors++; $display("FAIL fll_cfg got=%h want=%h", outs, {4'b0001, 4'b1101, 4'hA, 2'b00, 3'd2}); end
    step(3);                              // k+11
    checks++; if ({seq_state, fll_cfg_req, fll_range} !== {3'd2, 1'b1, 4'hA}) begin errors++; $display("FAIL fll_cfg_end got=%h want=%h", {seq_state, fll_cfg_req, fll_range}, {3'd2, 1'b1, 4'hA}); end
    step(1);                              // k+12
    checks++; if (outs !== {4'b0001, 4'b1010, 4'hA, 2'b00, 3'd3}) begin errors++; $display("FAIL fll_wait got=%h want=%h", outs, {4'b0001, 4'b1010, 4'hA, 2'b00, 3'd3}); end
    step(7); fll_lock = 1'b1;             // first sampled at edge k+20
    step(6);                              // k+25
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL fll_lock_early state=%0d want=3", seq_state); end
    step(1);                              // k+26
    checks++; if (outs !== {4'b0111, 4'b1010, 4'hA, 2'b00, 3'd4}) begin errors++; $display("FAIL fll_clk_en got=%h want=%h", outs, {4'b0111, 4'b1010, 4'hA, 2'b00, 3'd4}); end
    step(11);                             // k+37
    checks++; if ({seq_state, chip_rst_n} !== {3'd5, 1'b0}) begin errors++; $display("FAIL fll_chip_rst got=%b want=%b", {seq_state, chip_rst_n}, {3'd5, 1'b0}); end
    step(1);                              // k+38
    checks++; if (outs !== {4'b1111, 4'b1010, 4'hA, 2'b10, 3'd6}) begin errors++; $display("FAIL fll_run got=%h want=%h", outs, {4'b1111, 4'b1010, 4'hA, 2'b10, 3'd6}); end
  endtask

  task automatic test_lock_loss;
    fll_lock = 1'b0;                      // pin falls before edge j
    step(2);                              // j+1: synced lock still high at the FSM
    checks++; if ({seq_state, chip_ready} !== {3'd6, 1'b1}) begin errors++; $display("FAIL loss_early got=%b want=%b", {seq_state, chip_ready}, {3'd6, 1'b1}); end
    step(1);                              // j+2
    checks++; if (outs !== {4'b0011, 4'b0100, 4'hA, 2'b01, 3'd7}) begin errors++; $display("FAIL loss_error got=%h want=%h", outs, {4'b0011, 4'b0100, 4'hA, 2'b01, 3'd7}); end
    step(4);
    checks++; if (seq_state !== 3'd7) begin errors++; $display("FAIL loss_sticky state=%0d want=7", seq_state); end
    stop = 1'b1; step(1); stop = 1'b0;
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL loss_stop got=%h want=%h", outs, IDLE_V); end
  endtask

  task automatic test_lock_timeout;
    use_fll = 1'b1; async_mux_cfg = 1'b0; fll_range_cfg = 4'h5; fll_lock = 1'b0;
    start = 1'b1; step(1); start = 1'b0;  // k
    step(11);                             // k+11
    checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL tmo_cfg state=%0d want=2", seq_state); end
    step(1);                              // k+12
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL tmo_wait state=%0d want=3", seq_state); end
    step(63);                             // k+75
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL tmo_early state=%0d want=3", seq_state); end
    step(1);                              // k+76
    checks++; if (outs !== {4'b0000, 4'b0100, 4'h5, 2'b01, 3'd7}) begin errors++; $display("FAIL tmo_error got=%h want=%h", outs, {4'b0000, 4'b0100, 4'h5, 2'b01, 3'd7}); end
    stop = 1'b1; step(1); stop = 1'b0;
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL tmo_stop got=%h want=%h", outs, IDLE_V); end
  endtask

  task automatic test_glitchy_lock;
    logic [7:0] pat;
    pat = 8'b1110_1111;                   // applied MSB first: 1,1,1,0,1,1,1,1
    use_fll = 1'b1; fll_range_cfg = 4'h6; fll_lock = 1'b0;
    start = 1'b1; step(1); start = 1'b0;  // k
    step(12);                             // k+12
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL glitch_wait state=%0d want=3", seq_state); end
    for (int i = 0; i < 8; i++) begin     // pin sampled at k+13..k+20
      fll_lock = pat[7 - i];
      step(1);
    end
    // Without the dropout CLK_EN would have come at k+19; here we are at k+20.
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL glitch_restart state=%0d want=3", seq_state); end
    step(2);                              // k+22
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL glitch_early state=%0d want=3", seq_state); end
    step(1);                              // k+23
    checks++; if ({seq_state, chip_clk_en} !== {3'd4, 1'b1}) begin errors++; $display("FAIL glitch_clk_en got=%b want=%b", {seq_state, chip_clk_en}, {3'd4, 1'b1}); end
    stop = 1'b1; step(1); stop = 1'b0; fll_lock = 1'b0;
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL glitch_stop got=%h want=%h", outs, IDLE_V); end
  endtask

  task automatic test_back_to_back;
    use_fll = 1'b0; async_mux_cfg = 1'b1;
    start = 1'b1; step(1);                // k, start stays high
    step(4);                              // k+4
    checks++; if (seq_state !== 3'd5) begin errors++; $display("FAIL dis_chip_rst state=%0d want=5", seq_state); end
    stop = 1'b1; step(1); stop = 1'b0;
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL dis_stop got=%h want=%h", outs, IDLE_V); end
    step(5);
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL dis_no_relaunch state=%0d want=0", seq_state); end
    start = 1'b0; step(1);
    start = 1'b1; step(1); start = 1'b0;
    checks++; if ({seq_state, chip_clk_en, chip_async_mux} !== {3'd4, 2'b11}) begin errors++; $display("FAIL dis_relaunch got=%b want=%b", {seq_state, chip_clk_en, chip_async_mux}, {3'd4, 2'b11}); end
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic test_async_reset;
    use_fll = 1'b1; async_mux_cfg = 1'b1; fll_lock = 1'b0;
    start = 1'b1; step(1); start = 1'b0;  // k
    step(15);                             // k+15
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL arst_pre state=%0d want=3", seq_state); end
    #2 chipset_rst_n = 1'b0;
    #1;
    checks++; if (outs !== IDLE_V) begin errors++; $display("FAIL arst_immediate got=%h want=%h", outs, IDLE_V); end
    step(1);
    chipset_rst_n = 1'b1;
    use_fll = 1'b0; async_mux_cfg = 1'b0;
    start = 1'b1; step(1); start = 1'b0;  // k'
    step(11);                             // k'+11
    checks++; if (seq_state !== 3'd5) begin errors++; $display("FAIL arst_relaunch state=%0d want=5", seq_state); end
    step(1);                              // k'+12
    checks++; if ({seq_state, chip_ready} !== {3'd6, 1'b1}) begin errors++; $display("FAIL arst_run got=%b want=%b", {seq_state, chip_ready}, {3'd6, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_bypass_boot();
    test_fll_boot();
    test_lock_loss();
    test_lock_timeout();
    test_glitchy_lock();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
